// File: rtl/sample_pacer.sv
// Sample-rate pacer: divides clk into a sample tick, launches one conversion per tick,
// captures the returned result. Define SAMPLE_PACER_STATS_EN to build the overrun/timeout counters.
module sample_pacer #(
   parameter int PERIOD  = 50,
   parameter int TIMEOUT = 40,
   parameter int W       = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic [W-1:0] adc_data,
   input  logic         adc_valid,
   output logic         start,
   output logic [W-1:0] sample_o,
   input  logic         done,
   input  logic [W-1:0] result_i,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   output logic         busy,
   output logic [15:0]  overrun_cnt,
   output logic [15:0]  timeout_cnt
);

   localparam int CW = $clog2(PERIOD);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   if (PERIOD < 4) begin : g_bad_period
      $error("sample_pacer: PERIOD must be at least 4");
   end
   if (TIMEOUT >= PERIOD || TIMEOUT < 1) begin : g_bad_timeout
      $error("sample_pacer: TIMEOUT must be in 1..PERIOD-1");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [CW-1:0]   tick_cnt;
   logic [TW-1:0]   wait_cnt;
   logic [W-1:0]    hold_q;
   logic            tick;
   logic            launch;
   logic            capture;
   logic            timeout_hit;

   assign tick = (tick_cnt == CW'(PERIOD - 1)) && enable;

   // Dropping enable parks the divider at 0 so the next tick is a full period away.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt <= '0;
      end else if (!enable || tick_cnt == CW'(PERIOD - 1)) begin
         tick_cnt <= '0;
      end else begin
         // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
         tick_cnt <= tick_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      next_state  = state;
      launch      = 1'b0;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (tick) begin
               launch     = 1'b1;
               next_state = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            next_state = ST_WAIT;
         end
         ST_WAIT: begin
            // A done on the final allowed cycle still wins over the timeout.
            if (done) begin
               capture    = 1'b1;
               next_state = ST_IDLE;
            end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               next_state  = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   assign start = (state == ST_LAUNCH);
   assign busy  = (state != ST_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (state == ST_LAUNCH) begin
         wait_cnt <= '0;
      end else if (state == ST_WAIT && !done && !timeout_hit) begin
         wait_cnt <= wait_cnt + TW'(1);
      end
   end

   // A sample arriving on the tick cycle bypasses the hold register into the launch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q   <= '0;
         sample_o <= '0;
      end else begin
         if (adc_valid) begin
            hold_q <= adc_data;
         end
         if (launch) begin
            sample_o <= adc_valid ? adc_data : hold_q;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= capture;
         if (capture) begin
            out_data <= result_i;
         end
      end
   end

`ifdef SAMPLE_PACER_STATS_EN
   logic        overrun;
   logic [15:0] overrun_q;
   logic [15:0] timeout_q;

   assign overrun = tick && (state != ST_IDLE);

   // Both counters stick at all-ones until the next reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun_q <= '0;
         timeout_q <= '0;
      end else begin
         if (overrun && overrun_q != 16'hFFFF) begin
            overrun_q <= overrun_q + 16'd1;
         end
         if (timeout_hit && timeout_q != 16'hFFFF) begin
            timeout_q <= timeout_q + 16'd1;
         end
      end
   end

   assign overrun_cnt = overrun_q;
   assign timeout_cnt = timeout_q;
`else
   assign overrun_cnt = 16'h0000;
   assign timeout_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sample_pacer.sv
// Directed bench for sample_pacer: pacing, round trip, timeout, overrun, bypass, enable and reset.
module tb_sample_pacer;

   localparam int W = 32;

`ifdef SAMPLE_PACER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         enable;
   logic [W-1:0] adc_data;
   logic         adc_valid;
   logic         done;
   logic         done_ov;
   logic [W-1:0] result_i;

   logic         start, out_valid, busy;
   logic [W-1:0] sample_o, out_data;
   logic [15:0]  overrun_cnt, timeout_cnt;

   logic         start_ov, out_valid_ov, busy_ov;
   logic [W-1:0] sample_o_ov, out_data_ov;
   logic [15:0]  overrun_cnt_ov, timeout_cnt_ov;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   sample_pacer #(.PERIOD(8), .TIMEOUT(5), .W(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .adc_data    (adc_data),
      .adc_valid   (adc_valid),
      .start       (start),
      .sample_o    (sample_o),
      .done        (done),
      .result_i    (result_i),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .busy        (busy),
      .overrun_cnt (overrun_cnt),
      .timeout_cnt (timeout_cnt)
   );

   // Longer timeout so each conversion straddles the following tick.
   sample_pacer #(.PERIOD(8), .TIMEOUT(7), .W(W)) dut_ov (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .adc_data    (adc_data),
      .adc_valid   (adc_valid),
      .start       (start_ov),
      .sample_o    (sample_o_ov),
      .done        (done_ov),
      .result_i    (result_i),
      .out_data    (out_data_ov),
      .out_valid   (out_valid_ov),
      .busy        (busy_ov),
      .overrun_cnt (overrun_cnt_ov),
      .timeout_cnt (timeout_cnt_ov)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      adc_data  = '0;
      adc_valid = 1'b0;
      done      = 1'b0;
      done_ov   = 1'b0;
      result_i  = '0;
      repeat (2) @(negedge clk);

      check("reset_start",     32'(start),       32'd0);
      check("reset_busy",      32'(busy),        32'd0);
      check("reset_out_valid", 32'(out_valid),   32'd0);
      check("reset_sample_o",  sample_o,         32'd0);
      check("reset_out_data",  out_data,         32'd0);
      check("reset_overrun",   32'(overrun_cnt), 32'd0);
      check("reset_timeout",   32'(timeout_cnt), 32'd0);

      // Cycle 0: divider at 0 with enable high.
      reset  = 1'b0;
      enable = 1'b1;
      cyc    = 0;

      step(); step(); step();                       // cycle 3
      adc_data  = 32'h0000_1234;
      adc_valid = 1'b1;
      step();                                       // cycle 4
      adc_valid = 1'b0;
      adc_data  = 32'hFFFF_FFFF;
      step(); step(); step();                       // cycle 7 (tick)
      check("pre_tick_start", 32'(start), 32'd0);
      check("pre_tick_busy",  32'(busy),  32'd0);

      step();                                       // cycle 8
      check("launch1_start",    32'(start),    32'd1);
      check("launch1_sample",   sample_o,      32'h0000_1234);
      check("launch1_busy",     32'(busy),     32'd1);
      check("ov_launch1_sample", sample_o_ov,  32'h0000_1234);
      check("ov_no_overrun_yet", 32'(overrun_cnt_ov), 32'd0);

      step();                                       // cycle 9
      check("start_one_cycle", 32'(start), 32'd0);

      step();                                       // cycle 10
      done     = 1'b1;
      result_i = 32'h4591_A000;
      step();                                       // cycle 11
      done = 1'b0;
      check("rt_out_valid", 32'(out_valid), 32'd1);
      check("rt_out_data",  out_data,       32'h4591_A000);
      check("rt_idle",      32'(busy),      32'd0);

      step();                                       // cycle 12
      check("out_valid_one_cycle", 32'(out_valid), 32'd0);

      step();                                       // cycle 13: done in IDLE
      done     = 1'b1;
      result_i = 32'hDEAD_BEEF;
      step();                                       // cycle 14
      done = 1'b0;
      check("idle_done_no_valid", 32'(out_valid), 32'd0);
      check("idle_done_no_cap",   out_data,       32'h4591_A000);

      step();                                       // cycle 15 (tick)
      check("ov_busy_at_tick", 32'(busy_ov), 32'd1);

      step();                                       // cycle 16
      check("launch2_start",  32'(start), 32'd1);
      check("launch2_reuse",  sample_o,   32'h0000_1234);
      check("ov_overrun_1",   32'(overrun_cnt_ov), STATS ? 32'd1 : 32'd0);
      check("ov_timeout_1",   32'(timeout_cnt_ov), STATS ? 32'd1 : 32'd0);
      check("ov_tick_dropped", 32'(start_ov),      32'd0);
      check("ov_idle",        32'(busy_ov),        32'd0);
      check("ov_no_valid",    32'(out_valid_ov),   32'd0);
      check("ov_no_data",     out_data_ov,         32'd0);
      done     = 1'b1;                              // done in LAUNCH
      result_i = 32'h1111_1111;

      step();                                       // cycle 17: WAIT entry
      done = 1'b0;
      check("launch_done_no_valid", 32'(out_valid), 32'd0);
      check("wait_busy",            32'(busy),      32'd1);

      step(); step(); step(); step();               // cycle 21
      check("to_still_busy", 32'(busy), 32'd1);
      step();                                       // cycle 22
      check("to_idle",     32'(busy),        32'd0);
      check("to_no_valid", 32'(out_valid),   32'd0);
      check("to_count",    32'(timeout_cnt), STATS ? 32'd1 : 32'd0);
      check("to_data_kept", out_data,        32'h4591_A000);

      step();                                       // cycle 23 (tick) with fresh sample
      adc_data  = 32'h0000_ABCD;
      adc_valid = 1'b1;
      step();                                       // cycle 24
      adc_valid = 1'b0;
      check("bypass_start",  32'(start),    32'd1);
      check("bypass_sample", sample_o,      32'h0000_ABCD);
      check("ov_relaunch",   32'(start_ov), 32'd1);

      step();                                       // cycle 25
      check("bypass_start_one_cycle", 32'(start), 32'd0);
      step(); step(); step(); step();               // cycle 29: last WAIT cycle
      done     = 1'b1;
      result_i = 32'h0000_5A5A;
      step();                                       // cycle 30
      done = 1'b0;
      check("edge_out_valid", 32'(out_valid),   32'd1);
      check("edge_out_data",  out_data,         32'h0000_5A5A);
      check("edge_no_timeout", 32'(timeout_cnt), STATS ? 32'd1 : 32'd0);
      check("edge_idle",      32'(busy),        32'd0);

      step(); step();                               // cycle 32
      check("ov_overrun_2", 32'(overrun_cnt_ov), STATS ? 32'd2 : 32'd0);
      check("ov_timeout_2", 32'(timeout_cnt_ov), STATS ? 32'd2 : 32'd0);

      step(); step();                               // cycle 34: mid-WAIT
      check("pre_reset_busy", 32'(busy), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("async_start",     32'(start),          32'd0);
      check("async_busy",      32'(busy),           32'd0);
      check("async_out_valid", 32'(out_valid),      32'd0);
      check("async_out_data",  out_data,            32'd0);
      check("async_sample",    sample_o,            32'd0);
      check("async_timeout",   32'(timeout_cnt),    32'd0);
      check("async_ov_overrun", 32'(overrun_cnt_ov), 32'd0);
      check("async_ov_timeout", 32'(timeout_cnt_ov), 32'd0);
      enable = 1'b0;

      @(negedge clk);
      reset    = 1'b0;
      cyc      = 0;
      done     = 1'b1;
      result_i = 32'h7777_7777;
      step();
      done = 1'b0;
      check("post_reset_done_valid", 32'(out_valid), 32'd0);
      check("post_reset_done_data",  out_data,       32'd0);

      for (int i = 0; i < 8; i++) begin
         step();
         check("disabled_no_start", 32'(start), 32'd0);
      end

      // Enable drop at +3 restarts the divider, so the launch lands at +12.
      enable = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         step();
         if (i == 3) enable = 1'b0;
         if (i == 4) enable = 1'b1;
         check("enable_restart", 32'(start), (i == 12) ? 32'd1 : 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sample_pacer.md
Name: sample_pacer

Overview:
- Upstream control stage for the convert → IIR → convert chain.
- Divides the system clock into a fixed sample-rate tick and holds the latest input sample stable.
- On each tick, issues a single-cycle start to the converter/filter path and waits for its done strobe.
- Captures the returned result and presents it with a one-cycle valid pulse; counts overruns and timeouts.

Parameters:
- PERIOD, 50: clocks per sample tick (50 MHz / 1 MHz); must be ≥ 4.
- TIMEOUT, 40: max clocks spent in WAIT before the conversion is abandoned; must be < PERIOD.
- W, 32: sample/result data width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  tick generator run enable.
- adc_data  in  W  raw input sample.
- adc_valid  in  1  adc_data is valid this cycle.
- start  out  1  one-cycle conversion launch strobe.
- sample_o  out  W  held sample presented to the converter; stable from launch until return to IDLE.
- done  in  1  conversion/filter complete strobe.
- result_i  in  W  result, valid when done=1.
- out_data  out  W  last captured result.
- out_valid  out  1  one-cycle pulse when out_data updates.
- busy  out  1  FSM not in IDLE.
- overrun_cnt  out  16  ticks dropped because FSM was busy.
- timeout_cnt  out  16  conversions abandoned on timeout.

Behaviour:
- Reset (async, active-high):
  - All outputs 0; tick counter 0; hold register 0; FSM = IDLE.
  - Applies immediately, including mid-conversion; an in-flight conversion is discarded.
- Tick counter:
  - While enable=1, counts 0..PERIOD-1 and wraps.
  - tick = (count == PERIOD-1) && enable.
  - enable=0 clears count to 0 next cycle, so no tick is generated; an in-flight conversion still completes normally.
- Hold register:
  - Loads adc_data on every cycle with adc_valid=1, in any state.
  - sample_o is a separate register, loaded from the hold register only on the IDLE→LAUNCH transition.
  - If no new adc_valid arrived since the last launch, the previous sample is reused (zero-order hold).
  - When adc_valid and tick coincide, the new adc_data is the value launched: bypass into sample_o.
- FSM states:
  - IDLE: on tick → LAUNCH and load sample_o.
  - LAUNCH: start=1 for exactly this cycle; → WAIT. Wait counter cleared.
  - WAIT:
    - done=1 → out_data ← result_i, out_valid=1 next cycle, → IDLE.
    - Otherwise wait counter increments.
    - Counter reaching TIMEOUT-1 without done → timeout_cnt+1, → IDLE, no out_valid.
    - done in the same cycle as the timeout condition counts as success.
  - done while in IDLE or LAUNCH: ignored (no capture, no count).
- Latency: tick at cycle N → start=1 at N+1 → done at D (D ≥ N+2) → out_valid=1 and out_data updated at D+1; FSM in IDLE at D+1.
- busy = (state != IDLE).
- Overrun: tick while state != IDLE → overrun_cnt+1 and the tick is dropped (no queued launch).
- Counters saturate at 16'hFFFF and clear only on reset.
- out_valid is never high for two consecutive cycles; start is never high for two consecutive cycles.

Optional Feature:
- Macro: SAMPLE_PACER_STATS_EN.
- Defined: overrun_cnt and timeout_cnt are implemented as above.
- Undefined: both counters are removed; the ports remain, tied to 16'h0000. Timeout still returns the FSM to IDLE; overruns still drop ticks.

Test Plan:
- Basic pacing (PERIOD=8, TIMEOUT=5, enable=1 from cycle 0): start pulses at cycles 8, 16, 24 exactly.
- Round trip:
  - adc_data=32'h0000_1234 with adc_valid at cycle 3.
  - done with result_i=32'h4591_A000 two cycles after start.
  - Expect sample_o=32'h1234 from cycle 8; out_valid=1 at cycle 11 with out_data=32'h4591_A000.
  - No further adc_valid: the next start re-launches 32'h1234.
- Timeout: done never asserted → FSM returns IDLE 5 cycles after the WAIT entry, timeout_cnt=1, out_valid stays 0; the next tick launches normally.
- Overrun (PERIOD=8, TIMEOUT=7, done withheld): overrun_cnt increments only for ticks arriving while busy=1; with stats macro undefined, both counters read 0.
- Coincident adc_valid and tick:
  - adc_data=32'hABCD with adc_valid on the tick cycle → sample_o=32'hABCD at the start cycle.
  - done on the timeout-boundary cycle → captured, timeout_cnt unchanged.
- Reset mid-WAIT: assert reset asynchronously → start, busy, out_valid and counters drop to 0 immediately; a done after release produces no out_valid.
